key_led_sequencer: RTL and testbench
====================================

Name: key_led_sequencer

Overview:
Parametrised successor of the board-level KEY-to-LEDR practice block. It synchronises and debounces two raw push-buttons, then drives an LED_W-wide LED bank from one of four selectable sequence patterns. KEY[0] or an optional auto-run tick advances the pattern. KEY[1] cycles the pattern mode. It sits between the board pins (KEY, LEDR) and replaces direct combinational key-to-LED mapping.

Parameters:
LED_W, 10, width of LED output bank (>=2)
DEBOUNCE, 4, consecutive stable synchronised samples required to accept a key level change (>=1)
AUTO_DIV, 8, auto-run step period in clk cycles (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
KEY  input  2  raw buttons, active-low (0 = pressed), asynchronous to clk
auto_en  input  1  1 = generate a step every AUTO_DIV cycles
LEDR  output  LED_W  registered pattern output
mode  output  2  current pattern mode, registered
step_pulse  output  1  one-cycle strobe, high in the cycle LEDR takes a step-updated value

Behaviour:
- Reset (rst_n=0 sampled at a rising edge): LEDR=0, mode=0, step_pulse=0, ping-pong dir=left, prescaler=0, debounce counters=0, sync flops and accepted key levels=1 (released). Reset mid-debounce or mid-pattern discards all pending state; no event fires on or after reset release unless a fresh stable press occurs.
- Sync: 2-flop synchroniser per key.
- Debounce per key: counter increments while sync level != accepted level, and clears when they are equal. When the counter reaches DEBOUNCE, accepted level <= sync level and the counter clears. A glitch shorter than DEBOUNCE cycles produces no event.
- Press event: accepted level 1->0, one-cycle internal pulse. A release (0->1) produces no event.
- Latency: a key held low from before edge t0 yields a press pulse registered at edge t0+DEBOUNCE+1. LEDR/mode/step_pulse update at the following edge (total DEBOUNCE+2 edges after t0).
- Auto tick: when auto_en=1, the prescaler counts 0..AUTO_DIV-1 and ticks in the cycle it equals AUTO_DIV-1, then wraps. When auto_en=0, the prescaler is held at 0.
- Step request = key0 press OR auto tick. If both occur in the same cycle, exactly one step is taken.
- Mode change (key1 press): mode <= mode+1, wrapping 3->0. The pattern loads the new mode's initial value and dir=left. step_pulse stays 0. If a mode change and a step request occur in the same cycle, the mode change wins and the step is dropped.
- Initial values: mode0 LEDR=0; mode1 LEDR=1; mode2 level=0 (LEDR=0); mode3 LEDR=1, dir=left.
- Mode 0 (binary): LEDR <= LEDR+1, modulo 2^LED_W (all-ones -> 0).
- Mode 1 (running light): rotate left by 1; bit LED_W-1 wraps to bit 0.
- Mode 2 (bar): level register, $clog2(LED_W+1) bits. Level increments 0..LED_W, then LED_W -> 0. LEDR = (1<<level)-1, so level=LED_W gives all ones.
- Mode 3 (ping-pong): single hot bit. Moves left while dir=left. When it reaches bit LED_W-1, dir flips and the next step moves it right. At bit 0 with dir=right, dir flips to left. The bit never leaves the bank and an end bit is never repeated on consecutive steps.
- step_pulse=1 exactly in the cycle following an accepted step request. It is 0 on mode changes and during reset.

Test Plan:
- Reset: rst_n=0 for 2 cycles with KEY=2'b11 -> LEDR=10'b0, mode=0, step_pulse=0. After release, with no key activity for 50 cycles, outputs are unchanged.
- Mode 0 latency and count: three clean KEY[0] presses (low 10 cycles, high 10 cycles) -> LEDR=1,2,3. Each step_pulse occurs exactly 6 edges (DEBOUNCE+2) after KEY[0] first sampled low. No event on release.
- Glitch: KEY[0] low for 3 cycles, then high -> LEDR and step_pulse unchanged. Low for 4 cycles -> exactly one step.
- Mode 1 wrap: one KEY[1] press -> mode=1, LEDR=10'b0000000001, no step_pulse. Nine KEY[0] presses -> LEDR=10'b1000000000. Tenth press -> 10'b0000000001.
- Mode 3 auto-run: mode=3, auto_en=1 -> one step every 8 cycles. After 9 steps LEDR=10'b1000000000, step 10 gives 10'b0100000000, and after 18 steps LEDR=10'b0000000001. Mode 2 under auto: 10 steps reach 10'h3FF, step 11 gives 0.
- Collisions and reset mid-op: KEY[0] and KEY[1] accepted in the same cycle -> mode increments, LEDR = new initial value, no step_pulse. An auto tick coinciding with a key0 press advances once. rst_n pulsed low during a debounce count -> no press event after release.

Source files
------------

// File: rtl/key_led_sequencer.sv
// Debounced two-button LED sequencer: KEY[0] or an auto-run tick steps the pattern,
// KEY[1] cycles between binary, running-light, bar and ping-pong modes.
module key_led_sequencer #(
  parameter int LED_W    = 10,
  parameter int DEBOUNCE = 4,
  parameter int AUTO_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       KEY,
  input  logic             auto_en,
  output logic [LED_W-1:0] LEDR,
  output logic [1:0]       mode,
  output logic             step_pulse
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int PW = $clog2(AUTO_DIV);
  localparam int LW = $clog2(LED_W + 1);

  typedef enum logic [1:0] {
    M_BIN  = 2'd0,
    M_RUN  = 2'd1,
    M_BAR  = 2'd2,
    M_PING = 2'd3
  } mode_e;

  logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]       acc_q, acc_d, press_q, press_d;
  logic [CW-1:0]    cnt_q [2];
  logic [CW-1:0]    cnt_d [2];
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick, step_req;
  mode_e            mode_q, mode_d;
  logic             dir_left_q, dir_left_d;
  logic [LW-1:0]    level_q, level_d;
  logic [LED_W-1:0] led_q, led_d, bar;
  logic             step_q, step_d;
  logic             go_left;

  // Synchroniser and per-key debounce; the counter holds consecutive mismatches
  // so a new level is accepted on the DEBOUNCE-th disagreeing sample.
  always_comb begin
    sync1_d = KEY;
    sync2_d = sync1_q;
    acc_d   = acc_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != acc_q[k]) begin
        if (cnt_q[k] == CW'(DEBOUNCE - 1)) acc_d[k] = sync2_q[k];
        else                                cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
    press_d = acc_q & ~acc_d;
  end

  assign tick     = auto_en && (presc_q == PW'(AUTO_DIV - 1));
  assign step_req = press_q[0] | tick;

  always_comb begin
    presc_d = '0;
    if (auto_en && !tick) presc_d = presc_q + 1'b1;
  end

  // Pattern engine: a mode change takes priority over (and swallows) a step.
  always_comb begin
    mode_d     = mode_q;
    dir_left_d = dir_left_q;
    level_d    = level_q;
    led_d      = led_q;
    step_d     = 1'b0;
    go_left    = dir_left_q;
    bar        = '0;
    if (press_q[1]) begin
      mode_d     = mode_e'(mode_q + 2'd1);
      dir_left_d = 1'b1;
      level_d    = '0;
      led_d      = (mode_d == M_RUN || mode_d == M_PING) ? LED_W'(1) : '0;
    end else if (step_req) begin
      step_d = 1'b1;
      case (mode_q)
        M_BIN: led_d = led_q + 1'b1;
        M_RUN: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        M_BAR: begin
          level_d = (level_q == LW'(LED_W)) ? '0 : level_q + 1'b1;
          for (int i = 0; i < LED_W; i++) bar[i] = (LW'(i) < level_d);
          led_d = bar;
        end
        default: begin
          // End bits force the direction so the dot can never leave the bank.
          if (led_q[LED_W-1])  go_left = 1'b0;
          else if (led_q[0])   go_left = 1'b1;
          led_d      = go_left ? (led_q << 1) : (led_q >> 1);
          dir_left_d = led_d[LED_W-1] ? 1'b0 : (led_d[0] ? 1'b1 : go_left);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      acc_q      <= '1;
      press_q    <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      presc_q    <= '0;
      mode_q     <= M_BIN;
      dir_left_q <= 1'b1;
      level_q    <= '0;
      led_q      <= '0;
      step_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      acc_q      <= acc_d;
      press_q    <= press_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      presc_q    <= presc_d;
      mode_q     <= mode_d;
      dir_left_q <= dir_left_d;
      level_q    <= level_d;
      led_q      <= led_d;
      step_q     <= step_d;
    end
  end

  assign LEDR       = led_q;
  assign mode       = mode_q;
  assign step_pulse = step_q;
endmodule

// File: tb/tb_key_led_sequencer.sv
// Bench for key_led_sequencer: directed key/auto stimulus checked every cycle against
// a step-count pattern model, plus hand-computed checkpoints.
module tb_key_led_sequencer;
  localparam int W    = 10;
  localparam int DEB  = 4;
  localparam int ADIV = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         auto_en = 1'b0;
  logic [1:0]   KEY = 2'b11;
  logic [W-1:0] LEDR;
  logic [1:0]   mode;
  logic         step_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  key_led_sequencer #(.LED_W(W), .DEBOUNCE(DEB), .AUTO_DIV(ADIV)) dut (
    .clk(clk), .rst_n(rst_n), .KEY(KEY), .auto_en(auto_en),
    .LEDR(LEDR), .mode(mode), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // LED image after p steps since entering mode m.
  function automatic logic [W-1:0] pattern(input int m, input int p);
    int q, b;
    case (m)
      0: return W'(p % (1 << W));
      1: return W'(1 << (p % W));
      2: begin q = p % (W + 1); return W'((1 << q) - 1); end
      default: begin
        q = p % (2 * (W - 1));
        b = (q < W) ? q : 2 * (W - 1) - q;
        return W'(1 << b);
      end
    endcase
  endfunction

  bit           m_valid = 1'b0;
  logic [W-1:0] e_led;
  int           e_mode, pos, arun;
  bit           e_step;
  bit           pend [2];
  bit           acc_m [2];
  bit           rawh [2][2];
  bit           syh  [2][DEB];

  // Model: key samples reach the debouncer two edges late; a level is accepted once
  // the last DEB synchronised samples all disagree with it.
  always @(posedge clk) begin : model
    bit tick, sv, alldiff;
    if (!rst_n) begin
      m_valid = 1'b1;
      e_led = '0; e_mode = 0; e_step = 1'b0; pos = 0; arun = 0;
      for (int k = 0; k < 2; k++) begin
        pend[k] = 1'b0; acc_m[k] = 1'b1;
        rawh[k][0] = 1'b1; rawh[k][1] = 1'b1;
        for (int i = 0; i < DEB; i++) syh[k][i] = 1'b1;
      end
    end else begin
      tick = auto_en && ((arun % ADIV) == ADIV - 1);
      arun = auto_en ? arun + 1 : 0;
      e_step = 1'b0;
      if (pend[1]) begin
        e_mode = (e_mode + 1) % 4;
        pos = 0;
      end else if (pend[0] || tick) begin
        pos++;
        e_step = 1'b1;
      end
      e_led = pattern(e_mode, pos);
      for (int k = 0; k < 2; k++) begin
        sv = rawh[k][1];
        rawh[k][1] = rawh[k][0];
        rawh[k][0] = KEY[k];
        for (int i = DEB - 1; i > 0; i--) syh[k][i] = syh[k][i-1];
        syh[k][0] = sv;
        alldiff = 1'b1;
        for (int i = 0; i < DEB; i++) if (syh[k][i] == acc_m[k]) alldiff = 1'b0;
        pend[k] = 1'b0;
        if (alldiff) begin
          pend[k] = acc_m[k];
          acc_m[k] = ~acc_m[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_LEDR", int'(LEDR), int'(e_led));
      chk("cyc_mode", int'(mode), e_mode);
      chk("cyc_step_pulse", int'(step_pulse), int'(e_step));
    end
  end

  task automatic key_pulse(input int k, input int low_cyc, output int lat, output int nst);
    lat = -1;
    nst = 0;
    @(negedge clk);
    KEY[k] = 1'b0;
    for (int i = 0; i < low_cyc; i++) begin
      @(posedge clk); #1;
      if (step_pulse) begin
        nst++;
        if (lat < 0) lat = i;
      end
    end
    @(negedge clk);
    KEY[k] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (step_pulse) nst++;
    end
  endtask

  task automatic wait_steps(input int n);
    int got = 0;
    for (int i = 0; i < n * ADIV + 20 && got < n; i++) begin
      @(posedge clk); #1;
      if (step_pulse) got++;
    end
    chk("wait_steps", got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, ns;
    repeat (2) @(negedge clk);
    chk("rst_LEDR", int'(LEDR), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_step", int'(step_pulse), 0);
    rst_n = 1'b1;
    ns = 0;
    repeat (50) begin @(posedge clk); #1; if (step_pulse) ns++; end
    chk("idle_steps", ns, 0);
    chk("idle_LEDR", int'(LEDR), 0);

    for (int i = 1; i <= 3; i++) begin
      key_pulse(0, 10, lat, ns);
      chk("m0_latency", lat, DEB + 2);
      chk("m0_steps", ns, 1);
      chk("m0_LEDR", int'(LEDR), i);
    end

    key_pulse(0, 3, lat, ns);
    chk("glitch3_steps", ns, 0);
    chk("glitch3_LEDR", int'(LEDR), 3);
    key_pulse(0, 4, lat, ns);
    chk("glitch4_steps", ns, 1);
    chk("glitch4_LEDR", int'(LEDR), 4);

    key_pulse(1, 10, lat, ns);
    chk("m1_enter_steps", ns, 0);
    chk("m1_enter_mode", int'(mode), 1);
    chk("m1_enter_LEDR", int'(LEDR), 1);
    for (int i = 0; i < 9; i++) key_pulse(0, 10, lat, ns);
    chk("m1_top_LEDR", int'(LEDR), 512);
    key_pulse(0, 10, lat, ns);
    chk("m1_wrap_LEDR", int'(LEDR), 1);

    key_pulse(1, 10, lat, ns);
    key_pulse(1, 10, lat, ns);
    chk("m3_enter_mode", int'(mode), 3);
    chk("m3_enter_LEDR", int'(LEDR), 1);
    @(negedge clk); auto_en = 1'b1;
    wait_steps(9);
    chk("m3_top_LEDR", int'(LEDR), 512);
    wait_steps(1);
    chk("m3_bounce_LEDR", int'(LEDR), 256);
    wait_steps(8);
    chk("m3_home_LEDR", int'(LEDR), 1);
    @(negedge clk); auto_en = 1'b0;

    for (int i = 0; i < 3; i++) key_pulse(1, 10, lat, ns);
    chk("m2_enter_mode", int'(mode), 2);
    chk("m2_enter_LEDR", int'(LEDR), 0);
    @(negedge clk); auto_en = 1'b1;
    wait_steps(10);
    chk("m2_full_LEDR", int'(LEDR), 1023);
    wait_steps(1);
    chk("m2_wrap_LEDR", int'(LEDR), 0);
    @(negedge clk); auto_en = 1'b0;

    @(negedge clk); KEY = 2'b00;
    ns = 0;
    repeat (10) begin @(posedge clk); #1; if (step_pulse) ns++; end
    @(negedge clk); KEY = 2'b11;
    repeat (10) begin @(posedge clk); #1; if (step_pulse) ns++; end
    chk("both_steps", ns, 0);
    chk("both_mode", int'(mode), 3);
    chk("both_LEDR", int'(LEDR), 1);

    // Press timed so its pulse lands on the first auto tick.
    @(negedge clk); auto_en = 1'b1;
    @(negedge clk); KEY[0] = 1'b0;
    ns = 0;
    repeat (9) begin @(posedge clk); #1; if (step_pulse) ns++; end
    chk("coincide_steps", ns, 1);
    chk("coincide_LEDR", int'(LEDR), 2);
    @(negedge clk); auto_en = 1'b0; KEY[0] = 1'b1;
    repeat (12) @(negedge clk);
    chk("coincide_after_LEDR", int'(LEDR), 2);

    @(negedge clk); KEY[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    KEY[0] = 1'b1;
    ns = 0;
    repeat (20) begin @(posedge clk); #1; if (step_pulse) ns++; end
    chk("midrst_steps", ns, 0);
    chk("midrst_LEDR", int'(LEDR), 0);
    chk("midrst_mode", int'(mode), 0);
    key_pulse(0, 10, lat, ns);
    chk("postrst_steps", ns, 1);
    chk("postrst_LEDR", int'(LEDR), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
